// File: rtl/stereo_line_splitter.sv
// Splits a side-by-side stereo line into time-aligned left/right pixel pairs.
// The first half-line is buffered and replayed against the live second half.
module stereo_line_splitter #(
   parameter int                  HALF_IMG_W = 32,
   parameter int                  IMG_H      = 64,
   parameter int                  PX_WIDTH   = 24,
   parameter int                  COL_WIDTH  = 11,
   parameter int                  ROW_WIDTH  = 10,
   parameter bit                  SWAP       = 1'b0,
   parameter logic [PX_WIDTH-1:0] FILL_LEFT  = PX_WIDTH'(24'h00ffff),
   parameter logic [PX_WIDTH-1:0] FILL_RIGHT = PX_WIDTH'(24'hff0000)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 de_in,
   input  logic                 h_sync_in,
   input  logic                 v_sync_in,
   input  logic [PX_WIDTH-1:0]  pixel_in,
   output logic                 de_out,
   output logic                 h_sync_out,
   output logic                 v_sync_out,
   output logic [PX_WIDTH-1:0]  pixel_left,
   output logic [PX_WIDTH-1:0]  pixel_right,
   output logic                 pair_valid,
   output logic [COL_WIDTH-1:0] col_out,
   output logic [ROW_WIDTH-1:0] row_out,
   output logic                 frame_start,
   output logic                 line_err
);

   localparam int ADDR_W = (HALF_IMG_W > 1) ? $clog2(HALF_IMG_W) : 1;
   localparam logic [COL_WIDTH-1:0] COL_ONE   = COL_WIDTH'(1);
   localparam logic [COL_WIDTH-1:0] HALF_C    = COL_WIDTH'(HALF_IMG_W);
   localparam logic [COL_WIDTH-1:0] HALF_LAST = COL_WIDTH'(HALF_IMG_W - 1);
   localparam logic [COL_WIDTH-1:0] LINE_END  = COL_WIDTH'(2 * HALF_IMG_W);
   localparam logic [ROW_WIDTH-1:0] ROW_ONE   = ROW_WIDTH'(1);
   localparam logic [ROW_WIDTH-1:0] ROW_LAST  = ROW_WIDTH'(IMG_H - 1);

   typedef enum logic [2:0] {
      S_WAIT,
      S_IDLE,
      S_FIRST,
      S_SECOND,
      S_OVR
   } state_t;

   state_t                state_q, state_d;
   logic [COL_WIDTH-1:0]  col_q, col_d;
   logic [ROW_WIDTH-1:0]  row_q, row_d;
   logic                  wr_en;
   logic                  pair_en;
   logic                  err_en;
   logic                  line_end;
   logic [COL_WIDTH-1:0]  col_rel;
   logic [ADDR_W-1:0]     wr_addr;
   logic [ADDR_W-1:0]     rd_addr;

   logic [PX_WIDTH-1:0]   line_mem [HALF_IMG_W];
   logic [PX_WIDTH-1:0]   rd_data_q;

   // Stage 1: control aligned with the synchronous buffer read
   logic                  pair_s1_q, pair_s1_d;
   logic                  err_s1_q, err_s1_d;
   logic                  fs_s1_q, fs_s1_d;
   logic [COL_WIDTH-1:0]  col_s1_q, col_s1_d;
   logic [ROW_WIDTH-1:0]  row_s1_q, row_s1_d;
   logic                  de_s1_q, de_s1_d;
   logic                  hs_s1_q, hs_s1_d;
   logic                  vs_s1_q, vs_s1_d;
   logic [PX_WIDTH-1:0]   pix_s1_q, pix_s1_d;

   // Stage 2: registered outputs
   logic                  de_out_q, de_out_d;
   logic                  hs_out_q, hs_out_d;
   logic                  vs_out_q, vs_out_d;
   logic [PX_WIDTH-1:0]   pixel_left_q, pixel_left_d;
   logic [PX_WIDTH-1:0]   pixel_right_q, pixel_right_d;
   logic                  pair_valid_q, pair_valid_d;
   logic [COL_WIDTH-1:0]  col_out_q, col_out_d;
   logic [ROW_WIDTH-1:0]  row_out_q, row_out_d;
   logic                  frame_start_q, frame_start_d;
   logic                  line_err_q, line_err_d;

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      wr_en    = 1'b0;
      pair_en  = 1'b0;
      err_en   = 1'b0;
      line_end = 1'b0;

      if (v_sync_in) begin
         // Blanking aborts any line silently; a line still active after
         // reset keeps the block waiting for its end.
         col_d = '0;
         row_d = '0;
         if ((state_q != S_WAIT) || !de_in) begin
            state_d = S_IDLE;
         end
      end else begin
         case (state_q)
            S_WAIT: begin
               if (!de_in) begin
                  state_d = S_IDLE;
               end
            end
            S_IDLE: begin
               col_d = '0;
               if (de_in) begin
                  wr_en   = 1'b1;
                  col_d   = COL_ONE;
                  state_d = S_FIRST;
               end
            end
            S_FIRST: begin
               if (de_in) begin
                  wr_en = 1'b1;
                  col_d = col_q + COL_ONE;
                  if (col_q == HALF_LAST) begin
                     state_d = S_SECOND;
                  end
               end else begin
                  err_en   = 1'b1;
                  line_end = 1'b1;
                  state_d  = S_IDLE;
               end
            end
            S_SECOND: begin
               if (de_in) begin
                  if (col_q == LINE_END) begin
                     state_d = S_OVR;
                  end else begin
                     pair_en = 1'b1;
                     col_d   = col_q + COL_ONE;
                  end
               end else begin
                  err_en   = (col_q != LINE_END);
                  line_end = 1'b1;
                  state_d  = S_IDLE;
               end
            end
            S_OVR: begin
               if (!de_in) begin
                  err_en   = 1'b1;
                  line_end = 1'b1;
                  state_d  = S_IDLE;
               end
            end
            default: begin
               state_d = S_WAIT;
            end
         endcase

         if (line_end) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;
         end
      end
   end

   assign col_rel = col_q - HALF_C;
   assign rd_addr = col_rel[ADDR_W-1:0];
   assign wr_addr = (state_q == S_IDLE) ? '0 : col_q[ADDR_W-1:0];

   // NOTE: the line buffer has no reset; it is always written before it is
   // read, and a reset port would prevent mapping it onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         line_mem[wr_addr] <= pixel_in;
      end
      rd_data_q <= line_mem[rd_addr];
   end

   always_comb begin
      pair_s1_d = pair_en;
      err_s1_d  = err_en;
      col_s1_d  = pair_en ? col_rel : '0;
      row_s1_d  = row_q;
      fs_s1_d   = pair_en && (row_q == '0) && (col_rel == '0);
      de_s1_d   = de_in;
      hs_s1_d   = h_sync_in;
      vs_s1_d   = v_sync_in;
      pix_s1_d  = pixel_in;
   end

   always_comb begin
      de_out_d      = de_s1_q;
      hs_out_d      = hs_s1_q;
      vs_out_d      = vs_s1_q;
      pair_valid_d  = pair_s1_q;
      col_out_d     = col_s1_q;
      row_out_d     = row_s1_q;
      frame_start_d = fs_s1_q;
      line_err_d    = err_s1_q;
      pixel_left_d  = FILL_LEFT;
      pixel_right_d = FILL_RIGHT;
      if (pair_s1_q) begin
         pixel_left_d  = SWAP ? pix_s1_q : rd_data_q;
         pixel_right_d = SWAP ? rd_data_q : pix_s1_q;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_WAIT;
         col_q         <= '0;
         row_q         <= '0;
         pair_s1_q     <= 1'b0;
         err_s1_q      <= 1'b0;
         fs_s1_q       <= 1'b0;
         col_s1_q      <= '0;
         row_s1_q      <= '0;
         de_s1_q       <= 1'b0;
         hs_s1_q       <= 1'b0;
         vs_s1_q       <= 1'b0;
         pix_s1_q      <= '0;
         de_out_q      <= 1'b0;
         hs_out_q      <= 1'b0;
         vs_out_q      <= 1'b0;
         pixel_left_q  <= '0;
         pixel_right_q <= '0;
         pair_valid_q  <= 1'b0;
         col_out_q     <= '0;
         row_out_q     <= '0;
         frame_start_q <= 1'b0;
         line_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         row_q         <= row_d;
         pair_s1_q     <= pair_s1_d;
         err_s1_q      <= err_s1_d;
         fs_s1_q       <= fs_s1_d;
         col_s1_q      <= col_s1_d;
         row_s1_q      <= row_s1_d;
         de_s1_q       <= de_s1_d;
         hs_s1_q       <= hs_s1_d;
         vs_s1_q       <= vs_s1_d;
         pix_s1_q      <= pix_s1_d;
         de_out_q      <= de_out_d;
         hs_out_q      <= hs_out_d;
         vs_out_q      <= vs_out_d;
         pixel_left_q  <= pixel_left_d;
         pixel_right_q <= pixel_right_d;
         pair_valid_q  <= pair_valid_d;
         col_out_q     <= col_out_d;
         row_out_q     <= row_out_d;
         frame_start_q <= frame_start_d;
         line_err_q    <= line_err_d;
      end
   end

   assign de_out      = de_out_q;
   assign h_sync_out  = hs_out_q;
   assign v_sync_out  = vs_out_q;
   assign pixel_left  = pixel_left_q;
   assign pixel_right = pixel_right_q;
   assign pair_valid  = pair_valid_q;
   assign col_out     = col_out_q;
   assign row_out     = row_out_q;
   assign frame_start = frame_start_q;
   assign line_err    = line_err_q;

endmodule

// File: tb/tb_stereo_line_splitter.sv
// Bench for stereo_line_splitter: two instances (SWAP=0/1) share one input
// stream; a line-position model predicts every output cycle.
module tb_stereo_line_splitter;

   localparam int          H      = 4;
   localparam int          IMG_H  = 2;
   localparam logic [23:0] FILL_L = 24'h00ffff;
   localparam logic [23:0] FILL_R = 24'hff0000;

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic        valid;
      logic [23:0] left;
      logic [23:0] right;
      logic [10:0] col;
      logic [9:0]  row;
      logic        fs;
      logic        err;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        de_in = 1'b0;
   logic        h_sync_in = 1'b0;
   logic        v_sync_in = 1'b0;
   logic [23:0] pixel_in = '0;

   logic        de_a, hs_a, vs_a, pv_a, fs_a, err_a;
   logic [23:0] left_a, right_a;
   logic [10:0] col_a;
   logic [9:0]  row_a;
   logic        de_b, hs_b, vs_b, pv_b, fs_b, err_b;
   logic [23:0] left_b, right_b;
   logic [10:0] col_b;
   logic [9:0]  row_b;

   int errors = 0;
   int checks = 0;

   // Reference model state: position of the next pixel within the line
   bit          armed;
   int          pos;
   int          row;
   logic [23:0] first_half [H];
   obs_t        exp_q [$];

   always #5 clk = ~clk;

   stereo_line_splitter #(.HALF_IMG_W(H), .IMG_H(IMG_H), .SWAP(1'b0)) dut_a (
      .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in),
      .v_sync_in(v_sync_in), .pixel_in(pixel_in),
      .de_out(de_a), .h_sync_out(hs_a), .v_sync_out(vs_a),
      .pixel_left(left_a), .pixel_right(right_a), .pair_valid(pv_a),
      .col_out(col_a), .row_out(row_a), .frame_start(fs_a), .line_err(err_a)
   );

   stereo_line_splitter #(.HALF_IMG_W(H), .IMG_H(IMG_H), .SWAP(1'b1)) dut_b (
      .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in),
      .v_sync_in(v_sync_in), .pixel_in(pixel_in),
      .de_out(de_b), .h_sync_out(hs_b), .v_sync_out(vs_b),
      .pixel_left(left_b), .pixel_right(right_b), .pair_valid(pv_b),
      .col_out(col_b), .row_out(row_b), .frame_start(fs_b), .line_err(err_b)
   );

   function automatic obs_t get_a();
      obs_t o;
      o.de = de_a; o.hs = hs_a; o.vs = vs_a; o.valid = pv_a;
      o.left = left_a; o.right = right_a; o.col = col_a; o.row = row_a;
      o.fs = fs_a; o.err = err_a;
      return o;
   endfunction

   function automatic obs_t get_b();
      obs_t o;
      o.de = de_b; o.hs = hs_b; o.vs = vs_b; o.valid = pv_b;
      o.left = left_b; o.right = right_b; o.col = col_b; o.row = row_b;
      o.fs = fs_b; o.err = err_b;
      return o;
   endfunction

   function automatic obs_t idle_entry();
      obs_t e;
      e       = '0;
      e.left  = FILL_L;
      e.right = FILL_R;
      return e;
   endfunction

   function automatic obs_t swapped(input obs_t e);
      obs_t s;
      s = e;
      if (e.valid) begin
         s.left  = e.right;
         s.right = e.left;
      end
      return s;
   endfunction

   // Pairs come from line positions H..2H-1; any line end other than exactly
   // 2H pixels is an error; blanking or a line alive at reset aborts quietly.
   function automatic obs_t model_step(input logic de, input logic hs,
                                       input logic vs, input logic [23:0] px);
      obs_t e;
      e     = idle_entry();
      e.de  = de;
      e.hs  = hs;
      e.vs  = vs;
      e.row = 10'(row);
      if (!armed) begin
         if (!de) armed = 1'b1;
      end else if (vs) begin
         pos = 0;
         row = 0;
      end else if (de) begin
         if (pos < H) begin
            first_half[pos] = px;
         end else if (pos < 2 * H) begin
            e.valid = 1'b1;
            e.left  = first_half[pos - H];
            e.right = px;
            e.col   = 11'(pos - H);
            e.fs    = (row == 0) && (pos == H);
         end
         pos++;
      end else if (pos > 0) begin
         e.err = (pos != 2 * H);
         row   = (row + 1) % IMG_H;
         pos   = 0;
      end
      return e;
   endfunction

   task automatic check(input string tag, input obs_t got, input obs_t want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, want);
      end
   endtask

   task automatic model_reset();
      armed = 1'b0;
      pos   = 0;
      row   = 0;
      exp_q.delete();
      exp_q.push_back(idle_entry());
   endtask

   task automatic step(input logic de, input logic hs, input logic vs,
                       input logic [23:0] px);
      obs_t e;
      @(negedge clk);
      de_in     = de;
      h_sync_in = hs;
      v_sync_in = vs;
      pixel_in  = px;
      exp_q.push_back(model_step(de, hs, vs, px));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("out_swap0", get_a(), e);
      check("out_swap1", get_b(), swapped(e));
   endtask

   task automatic send_line(input int len);
      for (int i = 0; i < len; i++) step(1'b1, 1'b0, 1'b0, 24'($urandom));
   endtask

   task automatic gap(input int n, input logic vs);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'($urandom_range(0, 1)), vs, 24'($urandom));
   endtask

   // Asynchronous reset in the middle of a cycle; released just after an edge.
   task automatic pulse_reset();
      #2 rst = 1'b1;
      #1;
      check("reset_async_swap0", get_a(), '0);
      check("reset_async_swap1", get_b(), '0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", get_a(), '0);
      #1 rst = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_swap0", get_a(), '0);
      check("reset_swap1", get_b(), '0);
      #1 rst = 1'b0;
      gap(3, 1'b0);

      // Nominal lines, then short and long lines
      send_line(2 * H);     gap(2, 1'b0);
      send_line(6);         gap(2, 1'b0);
      send_line(10);        gap(3, 1'b0);
      send_line(2 * H);     gap(2, 1'b0);

      // Reset in the middle of a line, released while the line continues
      send_line(2);
      pulse_reset();
      send_line(3);         gap(2, 1'b0);
      send_line(2 * H);     gap(2, 1'b0);

      // Frame wrap with IMG_H=2, then a line cut by vertical blanking
      gap(2, 1'b1);         gap(1, 1'b0);
      send_line(2 * H);     gap(2, 1'b0);
      send_line(2 * H);     gap(2, 1'b0);
      send_line(2 * H);     gap(2, 1'b0);
      send_line(3);
      step(1'b1, 1'b0, 1'b1, 24'($urandom));
      step(1'b1, 1'b0, 1'b1, 24'($urandom));
      gap(2, 1'b1);         gap(2, 1'b0);
      send_line(2 * H);     gap(2, 1'b0);

      // Random line lengths, gaps, blanking and blanking cuts
      for (int n = 0; n < 40; n++) begin
         int len;
         len = $urandom_range(1, 2 * H + 3);
         if ($urandom_range(0, 2) != 0) len = 2 * H;
         if ($urandom_range(0, 7) == 0) begin
            send_line(len / 2 + 1);
            step(1'b1, 1'b0, 1'b1, 24'($urandom));
         end else begin
            send_line(len);
         end
         gap($urandom_range(1, 4), 1'($urandom_range(0, 5) == 0));
      end
      gap(3, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
